// File: rtl/sci_initiator.sv
// SCI initiator: serialises host register reads/writes onto a per-responder
// chip-selected request line and collects ACK-strobed serial read data.
module sci_initiator #(
  parameter int NUM_PERIPHERALS = 1,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 64,
  localparam int SEL_WIDTH      = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       host_req,
  input  logic                       host_wnr,
  input  logic [SEL_WIDTH-1:0]       host_sel,
  input  logic [ADDR_WIDTH-1:0]      host_addr,
  input  logic [DATA_WIDTH-1:0]      host_wdata,
  output logic                       host_ready,
  output logic                       host_done,
  output logic                       host_error,
  output logic [DATA_WIDTH-1:0]      host_rdata,
  output logic [NUM_PERIPHERALS-1:0] sci_csn,
  output logic                       sci_req,
  input  logic                       sci_resp,
  input  logic                       sci_ack
);

  localparam int SHIFT_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int BIT_CNT_W   = $clog2(SHIFT_WIDTH + 1);
  localparam int TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IN_CNT_W    = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SHIFT_OUT, WAIT_ACK, SHIFT_IN, DONE} state_t;

  state_t                      state;
  logic                        wnr_q;
  logic                        bad_sel_q;
  logic [SHIFT_WIDTH-1:0]      out_sr;
  logic [BIT_CNT_W-1:0]        bit_cnt;
  logic [TMO_W-1:0]            tmo_cnt;
  logic [DATA_WIDTH-1:0]       rd_sr;
  logic [IN_CNT_W-1:0]         in_cnt;

  logic                        sel_valid;
  logic [NUM_PERIPHERALS-1:0]  csn_sel;
  logic [BIT_CNT_W-1:0]        last_bit;
  logic [TMO_W-1:0]            tmo_next;
  logic                        tmo_hit;
  logic                        last_in;
  logic [DATA_WIDTH-1:0]       rd_next;

  always_comb begin
    sel_valid = (int'(host_sel) < NUM_PERIPHERALS);
    csn_sel   = '1;
    for (int i = 0; i < NUM_PERIPHERALS; i++) begin
      if (sel_valid && host_sel == SEL_WIDTH'(i)) csn_sel[i] = 1'b0;
    end
    last_bit = wnr_q ? BIT_CNT_W'(SHIFT_WIDTH) : BIT_CNT_W'(ADDR_WIDTH);
    tmo_next = tmo_cnt + TMO_W'(1);
    tmo_hit  = (tmo_next == TMO_W'(TIMEOUT_CYCLES));
    last_in  = (in_cnt == IN_CNT_W'(DATA_WIDTH - 1));
    rd_next  = DATA_WIDTH'({rd_sr, sci_resp});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wnr_q      <= 1'b0;
      bad_sel_q  <= 1'b0;
      out_sr     <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      rd_sr      <= '0;
      in_cnt     <= '0;
      sci_csn    <= '1;
      sci_req    <= 1'b0;
      host_ready <= 1'b1;
      host_done  <= 1'b0;
      host_error <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_done <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req) begin
            wnr_q      <= host_wnr;
            bad_sel_q  <= !sel_valid;
            out_sr     <= {host_addr, host_wdata};
            bit_cnt    <= '0;
            rd_sr      <= '0;
            in_cnt     <= '0;
            host_rdata <= '0;
            host_ready <= 1'b0;
            sci_csn    <= csn_sel;
            sci_req    <= host_wnr & sel_valid;
            state      <= SHIFT_OUT;
          end
        end
        // A bad select spends this one cycle with no CSN asserted, then reports
        SHIFT_OUT: begin
          if (bad_sel_q) begin
            state      <= DONE;
            host_done  <= 1'b1;
            host_error <= 1'b1;
            host_rdata <= '0;
            sci_csn    <= '1;
            sci_req    <= 1'b0;
          end else if (bit_cnt == last_bit) begin
            sci_req <= 1'b0;
            tmo_cnt <= '0;
            state   <= wnr_q ? WAIT_ACK : SHIFT_IN;
          end else begin
            sci_req <= out_sr[SHIFT_WIDTH-1];
            out_sr  <= out_sr << 1;
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (sci_ack) begin
            tmo_cnt    <= '0;
            state      <= DONE;
            host_done  <= 1'b1;
            host_error <= 1'b0;
            host_rdata <= rd_sr;
            sci_csn    <= '1;
          end else if (tmo_hit) begin
            rd_sr      <= '0;
            state      <= DONE;
            host_done  <= 1'b1;
            host_error <= 1'b1;
            host_rdata <= '0;
            sci_csn    <= '1;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        SHIFT_IN: begin
          if (sci_ack) begin
            tmo_cnt <= '0;
            rd_sr   <= rd_next;
            in_cnt  <= in_cnt + IN_CNT_W'(1);
            if (last_in) begin
              state      <= DONE;
              host_done  <= 1'b1;
              host_error <= 1'b0;
              host_rdata <= rd_next;
              sci_csn    <= '1;
            end
          end else if (tmo_hit) begin
            rd_sr      <= '0;
            state      <= DONE;
            host_done  <= 1'b1;
            host_error <= 1'b1;
            host_rdata <= '0;
            sci_csn    <= '1;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        DONE: begin
          host_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
